palette_stage: RTL and testbench
================================

# palette_stage

Parametrised successor of the palette/output stage, sitting between the layer compositor and the LCD pixel writer. It holds a per-layer colour palette, converts each pipeline colour index to RGB888, and drops transparent and repeat-coordinate pixels. Surviving pixels go into a synchronous first-word-fall-through FIFO with a valid/ready output port. Everything runs on a single pipeline clock; the LCD clock crossing is handled downstream.

## Interface
- LAYERS, 32, number of palette layers (power of 2, ≥2); LW = clog2(LAYERS)
- COLORS, 32, colour slots per layer (power of 2, ≥2); CW = clog2(COLORS)
- COORD_W, 11, width of x/y coordinates
- FIFO_DEPTH, 64, FIFO entries (power of 2, ≥4); AW = clog2(FIFO_DEPTH)

Ports:
- clk_pipe  in  1  pipeline clock; all state is on the rising edge
- rst  in  1  asynchronous, active-high reset
- ctrl_we  in  1  controller write strobe
- ctrl_layer  in  LW  controller layer select
- ctrl_color  in  CW  controller colour slot select
- ctrl_rgb  in  1  word select: 0 = {G,B}, 1 = {opaque,7'b0,R}
- ctrl_wdata  in  16  controller write data
- ctrl_rdata  out  16  controller read data, registered
- pix_valid  in  1  pipeline lookup request
- pix_layer  in  LW  pipeline layer
- pix_color  in  CW  pipeline colour index
- pix_x, pix_y  in  COORD_W  pixel coordinates
- pix_frame_start  in  1  clears the dedup history; qualified by pix_valid
- out_valid  out  1  FIFO non-empty; out_data is valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  24  RGB888 {R,G,B}
- fifo_count  out  AW+1  current occupancy
- fifo_empty, fifo_full, fifo_almost_full  out  1  status; almost_full = count ≥ FIFO_DEPTH−2
- drop_count  out  16  saturating count of accepted pixels lost because the FIFO was full
- pixel_found_new  out  1  stage-2 push qualifier, before the full check

## Operation
- **Palette RAM:** LAYERS×COLORS entries of 25 bits {opaque, R, G, B}. Reset does not clear it; contents are undefined until written.
- **Controller write** (ctrl_we=1):
  - ctrl_rgb=0 writes G = wdata[15:8], B = wdata[7:0].
  - ctrl_rgb=1 writes R = wdata[7:0], opaque = wdata[15].
- **Controller read** (every cycle): ctrl_rdata ← the selected word, with unused bits 0. A same-cycle write to the same word returns the old value.
- **Stage 1** (edge E0): registers pix_valid, pix_frame_start, pix_x and pix_y, and performs a synchronous palette read.
- **Stage 2:** pixel_found_new = valid & opaque & (frame_start_r | x_r≠last_x | y_r≠last_y).
- **Dedup history:** last_x and last_y update to x_r and y_r whenever pixel_found_new is high, whether or not the push succeeds.
- **Push:** occurs when pixel_found_new & (!full | pop). If pixel_found_new & full & !pop, the pixel is dropped and drop_count increments, saturating at 0xFFFF.
- **Pop:** occurs when out_valid & out_ready. Simultaneous push and pop leave the count unchanged.
- **FIFO:** circular buffer with AW-bit read/write pointers that wrap modulo FIFO_DEPTH; out_data = mem[rd_ptr].
- **Write hazard:** if a controller write and a pipeline lookup hit the same entry in the same cycle, the pipeline sees the old value.

## Timing
- **Reset values:**
  - ctrl_rdata = 0, out_valid = 0, out_data = 0 (don't-care while empty), fifo_count = 0
  - fifo_empty = 1, fifo_full = 0, fifo_almost_full = 0
  - drop_count = 0, pixel_found_new = 0
  - last_x and last_y = all ones; pipeline valid registers = 0
- **Pixel latency:** a pixel sampled at E0 is pushed at E1, and out_valid rises after E1 when the FIFO was empty. Throughput is one pixel per clock.
- **Controller read latency:** 1 clock.
- **Reset mid-operation:** the FIFO empties and in-flight stage-2 pixels are discarded immediately; palette contents are retained.
- **Upstream stall:** upstream must stall on fifo_almost_full. Two in-flight pixels always fit.

## Configuration
- **PALETTE_DEDUP_EN defined:** the coordinate dedup described above is active.
- **PALETTE_DEDUP_EN undefined:** pixel_found_new = valid & opaque, and the last_x/last_y registers are not built. Every opaque lookup is pushed, even repeats; pix_frame_start is ignored.

## Test plan
- **Controller word access:** write layer 3 / colour 5, word1 = 0x8012 and word0 = 0x3456 → reads return 0x8012 and 0x3456; a pipeline lookup of (3,5) outputs 0x123456.
- **Transparency:** write layer 0 / colour 1 with opaque = 0, then look it up at (10,10) → no push; fifo_count stays 0 and pixel_found_new = 0.
- **Dedup:** two opaque lookups at (7,9) on consecutive cycles → one push. A third lookup at (7,9) with pix_frame_start = 1 → a second push. With PALETTE_DEDUP_EN undefined → three pushes.
- **Fill and drop:** hold out_ready = 0 and push 66 distinct pixels with FIFO_DEPTH = 64 → fifo_full = 1, almost_full asserted at count 62, drop_count = 2.
- **Simultaneous push and pop:** at a full FIFO, apply out_ready = 1 and a new pixel in the same cycle → count stays 64, no drop, and pops return data in push order.
- **Reset mid-stream:** assert rst while the FIFO holds 10 entries → fifo_empty = 1, out_valid = 0 and drop_count = 0 immediately; a subsequent lookup still returns the earlier-written palette value.

Source files
------------

// File: rtl/palette_stage.sv
// -----------------------------------------------------------------------------
// palette_stage
//
// Palette/output stage between the layer compositor and the LCD pixel writer.
// Each pipeline lookup {layer, colour} is turned into RGB888 through a
// per-layer palette. Transparent pixels are dropped, and so are pixels whose
// coordinate repeats the previously accepted one when PALETTE_DEDUP_EN is
// defined. Surviving pixels enter a first-word-fall-through FIFO that is read
// through a valid/ready port.
//
// Build option:
//   PALETTE_DEDUP_EN  defined   -> drop repeat-coordinate pixels; history is
//                                  cleared by pix_frame_start
//                     undefined -> every opaque lookup is pushed; pix_x, pix_y
//                                  and pix_frame_start are ignored
//
// Ports:
//   clk_pipe, rst        pipeline clock, async active-high reset
//   ctrl_we              palette write strobe
//   ctrl_layer/_color    palette entry select
//   ctrl_rgb             word select: 0 = {G,B}, 1 = {opaque,7'b0,R}
//   ctrl_wdata           write data
//   ctrl_rdata           selected word, registered (1-clock latency)
//   pix_valid            lookup request
//   pix_layer/_color     lookup entry
//   pix_x, pix_y         pixel coordinate
//   pix_frame_start      clears dedup history (qualified by pix_valid)
//   out_valid/_ready     FIFO output handshake
//   out_data             RGB888 {R,G,B} at FIFO head (0 while empty)
//   fifo_count           occupancy, 0..FIFO_DEPTH
//   fifo_empty/_full     occupancy status
//   fifo_almost_full     count >= FIFO_DEPTH-2; upstream stalls on it
//   drop_count           saturating count of pixels lost to a full FIFO
//   pixel_found_new      stage-2 push qualifier, before the full check
// -----------------------------------------------------------------------------
module palette_stage #(
   parameter int LAYERS     = 32,
   parameter int COLORS     = 32,
   parameter int COORD_W    = 11,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                          clk_pipe,
   input  logic                          rst,
   input  logic                          ctrl_we,
   input  logic [$clog2(LAYERS)-1:0]     ctrl_layer,
   input  logic [$clog2(COLORS)-1:0]     ctrl_color,
   input  logic                          ctrl_rgb,
   input  logic [15:0]                   ctrl_wdata,
   output logic [15:0]                   ctrl_rdata,
   input  logic                          pix_valid,
   input  logic [$clog2(LAYERS)-1:0]     pix_layer,
   input  logic [$clog2(COLORS)-1:0]     pix_color,
   input  logic [COORD_W-1:0]            pix_x,
   input  logic [COORD_W-1:0]            pix_y,
   input  logic                          pix_frame_start,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [23:0]                   out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_empty,
   output logic                          fifo_full,
   output logic                          fifo_almost_full,
   output logic [15:0]                   drop_count,
   output logic                          pixel_found_new
);

   localparam int LW      = $clog2(LAYERS);
   localparam int CW      = $clog2(COLORS);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int ENTRIES = LAYERS * COLORS;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] AFULL_C = (AW+1)'(FIFO_DEPTH - 2);

   // Palette split into the two controller words so each word is written
   // independently without a read-modify-write.
   logic [15:0]       pal_gb_q [ENTRIES];   // {G, B}
   logic [8:0]        pal_or_q [ENTRIES];   // {opaque, R}

   logic [LW+CW-1:0]  ctrl_idx;
   logic [LW+CW-1:0]  pix_idx;
   logic [15:0]       rdata_q;

   logic              valid_q;
   logic [15:0]       s1_gb_q;
   logic [8:0]        s1_or_q;
   logic              found_new;
   logic [23:0]       s1_rgb;

   logic [23:0]       fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [15:0]       drop_q, drop_d;
   logic              empty, full, push, pop;

   assign ctrl_idx = {ctrl_layer, ctrl_color};
   assign pix_idx  = {pix_layer, pix_color};

   // ---------------- palette RAM (not reset) ----------------
   always_ff @(posedge clk_pipe) begin
      if (ctrl_we) begin
         if (ctrl_rgb) pal_or_q[ctrl_idx] <= {ctrl_wdata[15], ctrl_wdata[7:0]};
         else          pal_gb_q[ctrl_idx] <= ctrl_wdata;
      end
   end

   // Read ports sample the array before this edge's write lands, so both the
   // controller and the pipeline see the old value on a same-cycle collision.
   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) rdata_q <= '0;
      else if (ctrl_rgb)
         rdata_q <= {pal_or_q[ctrl_idx][8], 7'b0, pal_or_q[ctrl_idx][7:0]};
      else
         rdata_q <= pal_gb_q[ctrl_idx];
   end

   assign ctrl_rdata = rdata_q;

   // ---------------- stage 1 ----------------
   always_ff @(posedge clk_pipe) begin
      s1_gb_q <= pal_gb_q[pix_idx];
      s1_or_q <= pal_or_q[pix_idx];
   end

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= pix_valid;
   end

   assign s1_rgb = {s1_or_q[7:0], s1_gb_q};

   // ---------------- stage 2: transparency / dedup ----------------
`ifdef PALETTE_DEDUP_EN
   logic                fs_q;
   logic [COORD_W-1:0]  x_q, y_q;
   logic [COORD_W-1:0]  last_x_q, last_y_q;

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         fs_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         fs_q <= pix_frame_start;
         x_q  <= pix_x;
         y_q  <= pix_y;
      end
   end

   assign found_new = valid_q & s1_or_q[8]
                    & (fs_q | (x_q != last_x_q) | (y_q != last_y_q));

   // History follows every new pixel, even one that is then dropped as full.
   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         last_x_q <= '1;
         last_y_q <= '1;
      end else if (found_new) begin
         last_x_q <= x_q;
         last_y_q <= y_q;
      end
   end
`else
   logic unused_coord;
   assign unused_coord = ^{pix_frame_start, pix_x, pix_y};
   assign found_new    = valid_q & s1_or_q[8];
`endif

   assign pixel_found_new = found_new;

   // ---------------- output FIFO ----------------
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign pop   = !empty & out_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign push  = found_new & (!full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (found_new && full && !pop && (drop_q != 16'hFFFF))
         drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk_pipe) begin
      if (push) fifo_mem_q[wr_ptr_q] <= s1_rgb;
   end

   assign out_valid        = !empty;
   assign out_data         = empty ? 24'h0 : fifo_mem_q[rd_ptr_q];
   assign fifo_count       = count_q;
   assign fifo_empty       = empty;
   assign fifo_full        = full;
   assign fifo_almost_full = (count_q >= AFULL_C);
   assign drop_count       = drop_q;

endmodule

// File: tb/tb_palette_stage.sv
`timescale 1ns/1ps
module tb_palette_stage;

   localparam int LAYERS     = 32;
   localparam int COLORS     = 32;
   localparam int COORD_W    = 11;
   localparam int FIFO_DEPTH = 64;
   localparam int LW         = 5;
   localparam int CW         = 5;
   localparam int AW         = 6;
   localparam int ENTRIES    = LAYERS * COLORS;
`ifdef PALETTE_DEDUP_EN
   localparam int DEDUP_PUSHES = 2;
`else
   localparam int DEDUP_PUSHES = 3;
`endif

   logic                clk_pipe = 1'b0;
   logic                rst = 1'b1;
   logic                ctrl_we = 1'b0;
   logic [LW-1:0]       ctrl_layer = '0;
   logic [CW-1:0]       ctrl_color = '0;
   logic                ctrl_rgb = 1'b0;
   logic [15:0]         ctrl_wdata = '0;
   logic [15:0]         ctrl_rdata;
   logic                pix_valid = 1'b0;
   logic [LW-1:0]       pix_layer = '0;
   logic [CW-1:0]       pix_color = '0;
   logic [COORD_W-1:0]  pix_x = '0;
   logic [COORD_W-1:0]  pix_y = '0;
   logic                pix_frame_start = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [23:0]         out_data;
   logic [AW:0]         fifo_count;
   logic                fifo_empty, fifo_full, fifo_almost_full;
   logic [15:0]         drop_count;
   logic                pixel_found_new;

   palette_stage #(
      .LAYERS(LAYERS), .COLORS(COLORS), .COORD_W(COORD_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_pipe(clk_pipe), .rst(rst),
      .ctrl_we(ctrl_we), .ctrl_layer(ctrl_layer), .ctrl_color(ctrl_color),
      .ctrl_rgb(ctrl_rgb), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
      .pix_valid(pix_valid), .pix_layer(pix_layer), .pix_color(pix_color),
      .pix_x(pix_x), .pix_y(pix_y), .pix_frame_start(pix_frame_start),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_almost_full(fifo_almost_full), .drop_count(drop_count),
      .pixel_found_new(pixel_found_new)
   );

   always #5 clk_pipe = ~clk_pipe;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]          m_r [ENTRIES];
   logic [7:0]          m_g [ENTRIES];
   logic [7:0]          m_b [ENTRIES];
   bit                  m_opq [ENTRIES];
   bit                  k0 [ENTRIES];
   bit                  k1 [ENTRIES];
   logic [23:0]         q [$];
   int unsigned         m_drop;
   bit                  s1_v, s1_fs, s1_opq;
   logic [COORD_W-1:0]  s1_x, s1_y;
   logic [23:0]         s1_rgb;
   logic [COORD_W-1:0]  lx, ly;
   logic [15:0]         e_rd;
   bit                  e_rd_k;

   function automatic bit m_found();
`ifdef PALETTE_DEDUP_EN
      return s1_v && s1_opq && (s1_fs || s1_x != lx || s1_y != ly);
`else
      return s1_v && s1_opq;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_drop = 0;
      s1_v = 0; s1_fs = 0; s1_opq = 0;
      s1_x = '0; s1_y = '0; s1_rgb = '0;
      lx = '1; ly = '1;
      e_rd = '0; e_rd_k = 1;
   endtask

   task automatic check_outputs();
      check("out_valid",   32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
      check("fifo_count",  32'(fifo_count), 32'(q.size()));
      check("fifo_empty",  32'(fifo_empty), 32'(q.size() == 0));
      check("fifo_full",   32'(fifo_full), 32'(q.size() == FIFO_DEPTH));
      check("almost_full", 32'(fifo_almost_full), 32'(q.size() >= FIFO_DEPTH - 2));
      check("drop_count",  32'(drop_count), m_drop);
      check("found_new",   32'(pixel_found_new), 32'(m_found()));
      if (e_rd_k) check("ctrl_rdata", 32'(ctrl_rdata), 32'(e_rd));
   endtask

   // One clock: apply the current inputs to the model, advance, then compare.
   task automatic step();
      bit found, pop, full;
      int ci, pi;
      bit nv, nfs, nopq;
      logic [COORD_W-1:0] nx, ny;
      logic [23:0] nrgb;
      found = m_found();
      pop   = (q.size() != 0) && out_ready;
      full  = (q.size() == FIFO_DEPTH);
      ci = int'({ctrl_layer, ctrl_color});
      pi = int'({pix_layer, pix_color});
      if (ctrl_rgb) begin
         e_rd   = {m_opq[ci], 7'b0, m_r[ci]};
         e_rd_k = k1[ci];
      end else begin
         e_rd   = {m_g[ci], m_b[ci]};
         e_rd_k = k0[ci];
      end
      nv = pix_valid; nfs = pix_frame_start; nx = pix_x; ny = pix_y;
      nrgb = {m_r[pi], m_g[pi], m_b[pi]};
      nopq = m_opq[pi];
      if (ctrl_we) begin
         if (ctrl_rgb) begin
            m_r[ci] = ctrl_wdata[7:0]; m_opq[ci] = ctrl_wdata[15]; k1[ci] = 1;
         end else begin
            m_g[ci] = ctrl_wdata[15:8]; m_b[ci] = ctrl_wdata[7:0]; k0[ci] = 1;
         end
      end
      if (pop) void'(q.pop_front());
      if (found) begin
         if (!full || pop) q.push_back(s1_rgb);
         else if (m_drop < 65535) m_drop++;
         lx = s1_x; ly = s1_y;
      end
      s1_v = nv; s1_fs = nfs; s1_x = nx; s1_y = ny; s1_rgb = nrgb; s1_opq = nopq;
      @(posedge clk_pipe);
      @(negedge clk_pipe);
      check_outputs();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      pix_valid = 0; pix_frame_start = 0; ctrl_we = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic ctrl_write(input int l, input int c, input bit w, input logic [15:0] d);
      ctrl_we = 1; ctrl_layer = LW'(l); ctrl_color = CW'(c); ctrl_rgb = w; ctrl_wdata = d;
      step();
      ctrl_we = 0;
   endtask

   task automatic ctrl_read(input string tag, input int l, input int c, input bit w,
                            input logic [15:0] expv);
      ctrl_we = 0; ctrl_layer = LW'(l); ctrl_color = CW'(c); ctrl_rgb = w;
      step();
      check(tag, 32'(ctrl_rdata), 32'(expv));
   endtask

   task automatic set_pix(input int l, input int c, input int x, input int y, input bit fs);
      pix_valid = 1; pix_layer = LW'(l); pix_color = CW'(c);
      pix_x = COORD_W'(x); pix_y = COORD_W'(y); pix_frame_start = fs;
   endtask

   task automatic lookup(input int l, input int c, input int x, input int y, input bit fs);
      set_pix(l, c, x, y, fs);
      step();
      pix_valid = 0; pix_frame_start = 0;
   endtask

   task automatic drain();
      idle(2);
      out_ready = 1;
      for (int k = 0; k < 100 && q.size() != 0; k++) step();
      out_ready = 0;
      check("drain_empty", 32'(fifo_empty), 32'd1);
   endtask

   task automatic do_reset();
      ctrl_we = 0; pix_valid = 0; out_ready = 0;
      rst = 1;
      #1;
      model_reset();
      check_outputs();
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      @(negedge clk_pipe);
      rst = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < ENTRIES; i++) begin
         k0[i] = 0; k1[i] = 0; m_opq[i] = 0;
         m_r[i] = '0; m_g[i] = '0; m_b[i] = '0;
      end
      model_reset();
      #2;
      check_outputs();
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_found", 32'(pixel_found_new), 32'd0);
      @(negedge clk_pipe);
      rst = 0;

      // Fill the palette with random content; layer 2 is forced opaque.
      for (int i = 0; i < ENTRIES; i++) begin
         for (int w = 0; w < 2; w++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (w == 1 && (i >> CW) == 2) d[15] = 1'b1;
            ctrl_write(i >> CW, i % COLORS, w[0], d);
         end
      end

      // Controller word access and pipeline conversion.
      ctrl_write(3, 5, 1, 16'h8012);
      ctrl_write(3, 5, 0, 16'h3456);
      ctrl_read("rd_word1", 3, 5, 1, 16'h8012);
      ctrl_read("rd_word0", 3, 5, 0, 16'h3456);
      lookup(3, 5, 1, 1, 0);
      idle(1);
      check("lookup_rgb", 32'(out_data), 32'h123456);
      drain();

      // Transparent entry.
      ctrl_write(0, 1, 1, 16'h0055);
      lookup(0, 1, 10, 10, 0);
      check("transp_found", 32'(pixel_found_new), 32'd0);
      idle(1);
      check("transp_count", 32'(fifo_count), 32'd0);

      // Coordinate dedup.
      lookup(3, 5, 7, 9, 0);
      lookup(3, 5, 7, 9, 0);
      lookup(3, 5, 7, 9, 1);
      idle(2);
      check("dedup_pushes", 32'(fifo_count), 32'(DEDUP_PUSHES));
      drain();

      // Fill and drop.
      out_ready = 0;
      for (int i = 0; i < 66; i++) begin
         set_pix(2, i % COLORS, 100 + i, 200, 0);
         step();
         if (q.size() == 61) check("af_at_61", 32'(fifo_almost_full), 32'd0);
         if (q.size() == 62) check("af_at_62", 32'(fifo_almost_full), 32'd1);
      end
      idle(2);
      check("fill_full", 32'(fifo_full), 32'd1);
      check("fill_drop", 32'(drop_count), 32'd2);

      // Simultaneous push and pop at full.
      set_pix(2, 0, 400, 50, 0);
      step();
      out_ready = 1;
      for (int k = 1; k <= 4; k++) begin
         set_pix(2, k, 400 + k, 50, 0);
         step();
         check("simul_count", 32'(fifo_count), 32'd64);
      end
      pix_valid = 0;
      step();
      check("simul_last", 32'(fifo_count), 32'd64);
      step();
      check("simul_pop", 32'(fifo_count), 32'd63);
      check("simul_drop", 32'(drop_count), 32'd2);
      drain();

      // Reset mid-stream.
      for (int i = 0; i < 10; i++) begin
         set_pix(2, i, 500 + i, 60, 0);
         step();
      end
      idle(2);
      check("pre_rst_count", 32'(fifo_count), 32'd10);
      do_reset();
      lookup(3, 5, 20, 20, 0);
      idle(1);
      check("post_rst_rgb", 32'(out_data), 32'h123456);
      drain();

      // Randomized traffic with alternating consumer speed.
      for (int blk = 0; blk < 6; blk++) begin
         for (int c = 0; c < 500; c++) begin
            ctrl_we         = ($urandom_range(0, 7) == 0);
            ctrl_layer      = LW'($urandom);
            ctrl_color      = CW'($urandom);
            ctrl_rgb        = 1'($urandom);
            ctrl_wdata      = 16'($urandom);
            pix_valid       = ($urandom_range(0, 3) != 0);
            pix_layer       = LW'($urandom);
            pix_color       = CW'($urandom);
            pix_x           = COORD_W'($urandom_range(0, 2));
            pix_y           = COORD_W'($urandom_range(0, 1));
            pix_frame_start = ($urandom_range(0, 9) == 0);
            out_ready       = (blk % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            step();
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
